w6_rd_ctrl: RTL and testbench

Sequencer for the F6 fully-connected layer weight ROM (120 rows × 84 packed 8-bit weights, 7-bit address).
- Each row is issued once, in order 0..DEPTH-1.
- The matching C5 feature-buffer address is issued in lockstep with each row.
- MAC-array controls (clear, enable, last) are aligned to the synchronous-read data latency.
- Replays on downstream back-pressure so that no row is lost or duplicated at the consumer.
- Sits between the top-level layer scheduler and the w6 weight ROM / F6 MAC array.

---
 rtl/w6_rd_ctrl.sv | 148 ++++++++++++++
 tb/tb_w6_rd_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/w6_rd_ctrl.sv
// rtl/w6_rd_ctrl.sv - F6 weight ROM read sequencer with latency-aligned MAC controls and stall replay
// Optional: define W6_RD_CTRL_PERF_EN to enable the pass cycle counter on perf_cycles.

module w6_rd_ctrl #(
  parameter int DEPTH   = 120,
  parameter int AW      = 7,
  parameter int ROM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] w6_raddr,
  output logic [AW-1:0] x_raddr,
  input  logic          mac_ready,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_last,
  output logic [AW-1:0] mac_idx,
  output logic [15:0]   perf_cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [AW-1:0]      r_cnt;
  logic [AW-1:0]      w_cnt_nxt;
  logic [ROM_LAT-1:0] r_vld;
  logic [AW-1:0]      r_idx [ROM_LAT];

  logic               w_active;
  logic               w_head_vld;
  logic [AW-1:0]      w_head_idx;
  logic               w_stall;
  logic               w_issue;
  logic               w_last_take;

  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_head_vld  = r_vld[ROM_LAT-1];
  assign w_head_idx  = r_idx[ROM_LAT-1];
  // A valid head the MAC cannot take forces a full replay from that row.
  assign w_stall     = w_active && w_head_vld && !mac_ready;
  assign w_issue     = (r_state == S_RUN);
  assign w_last_take = w_head_vld && mac_ready && (w_head_idx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CLR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLR: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
      S_RUN: begin
        if (w_stall) begin
          w_cnt_nxt = w_head_idx;
        end else if (r_cnt == LAST_IDX) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      S_DRAIN: begin
        if (w_stall) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = w_head_idx;
        end else if (w_last_take) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Valid/index shift register models the ROM and feature-buffer read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_idx[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_issue && !w_stall;
      r_idx[0] <= r_cnt;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_vld[i] <= r_vld[i-1] && !w_stall;
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign busy     = (r_state == S_CLR) || w_active;
  assign done     = (r_state == S_DONE);
  assign mac_clr  = (r_state == S_CLR);
  assign w6_raddr = r_cnt;
  assign x_raddr  = r_cnt;
  assign mac_idx  = w_head_idx;
  assign mac_en   = w_head_vld && mac_ready;
  assign mac_last = mac_en && (w_head_idx == LAST_IDX);

`ifdef W6_RD_CTRL_PERF_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_perf <= '0;
    end else if (busy && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_w6_rd_ctrl.sv
// tb/tb_w6_rd_ctrl.sv - directed scoreboard bench for w6_rd_ctrl (ROM_LAT 1 and 3 instances)

module tb_w6_rd_ctrl;

  localparam int DEPTH = 120;
  localparam int AW    = 7;
`ifdef W6_RD_CTRL_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          mac_ready;
  logic          busy, done, mac_clr, mac_en, mac_last;
  logic [AW-1:0] w6_raddr, x_raddr, mac_idx;
  logic [15:0]   perf_cycles;

  logic          start3;
  logic          mac_ready3;
  logic          busy3, done3, mac_clr3, mac_en3, mac_last3;
  logic [AW-1:0] w6_raddr3, x_raddr3, mac_idx3;
  logic [15:0]   perf_cycles3;

  w6_rd_ctrl #(.DEPTH(DEPTH), .AW(AW), .ROM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w6_raddr(w6_raddr), .x_raddr(x_raddr), .mac_ready(mac_ready),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last),
    .mac_idx(mac_idx), .perf_cycles(perf_cycles)
  );

  w6_rd_ctrl #(.DEPTH(DEPTH), .AW(AW), .ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .w6_raddr(w6_raddr3), .x_raddr(x_raddr3), .mac_ready(mac_ready3),
    .mac_clr(mac_clr3), .mac_en(mac_en3), .mac_last(mac_last3),
    .mac_idx(mac_idx3), .perf_cycles(perf_cycles3)
  );

  int checks, errors;
  int cyc, base;
  int clr_n, clr_rel, done_n, done_rel, last_n, en_n, last_en_rel;
  int clr3_n, done3_n, last3_n, en3_n;
  int e1, e3;
  int q1[$];
  int q3[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    q1.delete();
    for (int i = 0; i < DEPTH; i++) q1.push_back(i);
    clr_n = 0; clr_rel = 0; done_n = 0; done_rel = 0;
    last_n = 0; en_n = 0; last_en_rel = 0;
    start = 1'b1;
    tick();
    base  = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_n != 0) break;
      tick();
    end
    chk("done_seen", done_n, 1);
    repeat (3) tick();
  endtask

  task automatic wait_head(input int idx, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (mac_en && (mac_idx == AW'(idx))) break;
      tick();
    end
    chk("head_found_en", mac_en, 1);
    chk("head_found_idx", mac_idx, idx);
  endtask

  // Scoreboard consumers: expected row order is queued at start, popped on each mac_en.
  initial begin
    forever begin
      @(negedge clk);
      chk("x_eq_w", x_raddr, w6_raddr);
      if (mac_clr) begin clr_n++; clr_rel = cyc - base + 1; end
      if (done) begin done_n++; done_rel = cyc - base + 1; end
      if (mac_last) last_n++;
      if (mac_en) begin
        en_n++;
        last_en_rel = cyc - base + 1;
        e1 = (q1.size() > 0) ? q1.pop_front() : -1;
        chk("mac_idx", mac_idx, e1);
        chk("mac_last", mac_last, (e1 == DEPTH - 1));
        chk("en_ready", mac_ready, 1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("x3_eq_w3", x_raddr3, w6_raddr3);
      chk("en3_while_not_ready", mac_en3 & ~mac_ready3, 0);
      if (mac_clr3) clr3_n++;
      if (done3) done3_n++;
      if (mac_last3) last3_n++;
      if (mac_en3) begin
        en3_n++;
        e3 = (q3.size() > 0) ? q3.pop_front() : -1;
        chk("mac_idx3", mac_idx3, e3);
        chk("mac_last3", mac_last3, (e3 == DEPTH - 1));
      end
    end
  end

  initial begin
    checks = 0; errors = 0; base = 0;
    clr_n = 0; clr_rel = 0; done_n = 0; done_rel = 0; last_n = 0; en_n = 0; last_en_rel = 0;
    clr3_n = 0; done3_n = 0; last3_n = 0; en3_n = 0;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; mac_ready = 1'b1; mac_ready3 = 1'b1;
    repeat (3) tick();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clr", mac_clr, 0);
    chk("rst_en", mac_en, 0);
    chk("rst_last", mac_last, 0);
    chk("rst_waddr", w6_raddr, 0);
    chk("rst_idx", mac_idx, 0);
    chk("rst_perf", perf_cycles, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_perf3", perf_cycles3, 0);
    rst_n = 1'b1;
    tick();

    // Nominal pass
    start_pass();
    chk("t1_busy_c1", busy, 1);
    chk("t1_perf_c1", perf_cycles, 0);
    wait_done(400);
    chk("t1_clr_n", clr_n, 1);
    chk("t1_clr_rel", clr_rel, 1);
    chk("t1_done_rel", done_rel, 123);
    chk("t1_en_n", en_n, DEPTH);
    chk("t1_last_n", last_n, 1);
    chk("t1_last_en_rel", last_en_rel, 122);
    chk("t1_sb_left", q1.size(), 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_perf", perf_cycles, (PERF_ON != 0) ? 122 : 0);

    // Single-cycle stall on row 37
    start_pass();
    chk("t2_perf_clr", perf_cycles, 0);
    wait_head(37, 200);
    mac_ready = 1'b0;
    tick();
    mac_ready = 1'b1;
    wait_done(400);
    chk("t2_done_rel", done_rel, 125);
    chk("t2_en_n", en_n, DEPTH);
    chk("t2_last_n", last_n, 1);
    chk("t2_sb_left", q1.size(), 0);
    chk("t2_perf", perf_cycles, (PERF_ON != 0) ? 124 : 0);

    // Five-cycle stall with the last row at the head
    start_pass();
    wait_head(DEPTH - 1, 300);
    mac_ready = 1'b0;
    tick();
    chk("t3_reissue_addr", w6_raddr, DEPTH - 1);
    repeat (4) tick();
    mac_ready = 1'b1;
    wait_done(400);
    chk("t3_done_rel", done_rel, 129);
    chk("t3_last_en_rel", last_en_rel, 128);
    chk("t3_done_after_last", done_rel - last_en_rel, 1);
    chk("t3_last_n", last_n, 1);
    chk("t3_en_n", en_n, DEPTH);
    chk("t3_sb_left", q1.size(), 0);

    // Starts while busy are ignored
    start_pass();
    for (int i = 0; i < 400; i++) begin
      if (done_n != 0) break;
      start = ((cyc - base + 1) == 10) || ((cyc - base + 1) == 50);
      tick();
    end
    start = 1'b0;
    repeat (3) tick();
    chk("t4_clr_n", clr_n, 1);
    chk("t4_done_n", done_n, 1);
    chk("t4_done_rel", done_rel, 123);
    chk("t4_en_n", en_n, DEPTH);

    // Reset mid-pass, then a fresh full pass
    start_pass();
    wait_head(60, 200);
    rst_n = 1'b0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_clr", mac_clr, 0);
    chk("t5_en", mac_en, 0);
    chk("t5_last", mac_last, 0);
    chk("t5_waddr", w6_raddr, 0);
    chk("t5_xaddr", x_raddr, 0);
    chk("t5_idx", mac_idx, 0);
    rst_n = 1'b1;
    q1.delete();
    done_n = 0;
    repeat (10) tick();
    chk("t5_no_done", done_n, 0);
    chk("t5_idle", busy, 0);
    start_pass();
    wait_done(400);
    chk("t5_done_rel", done_rel, 123);
    chk("t5_en_n", en_n, DEPTH);
    chk("t5_last_n", last_n, 1);
    chk("t5_sb_left", q1.size(), 0);

    // ROM_LAT=3 with periodic back-pressure; strict 1/0 alternation never lets a
    // replayed head land on a ready cycle (replay penalty is even), so 1,1,0 is used.
    q3.delete();
    for (int i = 0; i < DEPTH; i++) q3.push_back(i);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (done3_n != 0) break;
      mac_ready3 = ((i % 3) != 2);
      tick();
    end
    mac_ready3 = 1'b1;
    repeat (3) tick();
    chk("t6_en_n", en3_n, DEPTH);
    chk("t6_done_n", done3_n, 1);
    chk("t6_last_n", last3_n, 1);
    chk("t6_clr_n", clr3_n, 1);
    chk("t6_sb_left", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
